sdf_fft_reorder_64: RTL and testbench

//  Output reorder buffer for the 64-point SDF FFT datapath. Accepts the FFT output

---
 rtl/sdf_fft_reorder_64_if.sv | 30 +++
 rtl/sdf_fft_reorder_64.sv | 168 ++++++++++++++++
 tb/tb_sdf_fft_reorder_64.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdf_fft_reorder_64_if.sv
// Stream bundle for the 64-point FFT reorder buffer: bit-reversed input stream,
// natural-order output stream and the two sticky status flags.
interface sdf_fft_reorder_64_if #(
  parameter int DW = 32
);
  // Both streams: a beat transfers on a rising edge where valid & ready are both high.
  // The source holds valid and its payload stable until that transfer (the input side
  // may still offer without waiting; an offer while in_ready=0 is dropped and flagged).
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eof;
  logic          ovf;
  logic          err;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eof, ovf, err
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eof, ovf, err
  );
endinterface

// File: rtl/sdf_fft_reorder_64.sv
// Ping-pong reorder buffer: bit-reversed FFT output in, natural-order frames out.
// Optional build macro OUT_SCALE_EN divides re/im by N (arithmetic shift) on the output path.
module sdf_fft_reorder_64 #(
  parameter int N     = 64,
  parameter int LOG2N = 6,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  sdf_fft_reorder_64_if.slave   bus
);
  localparam int HW = DW / 2;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [DW-1:0]    mem [2*N];
  logic [1:0]       full;
  logic             wbank, rbank, ibank;
  logic [LOG2N-1:0] wcnt, rcnt, iaddr;

  logic             in_rdy, accept, resync, frame_done;
  logic [LOG2N-1:0] wr_addr;

  logic             rd_v, rd_sof, rd_eof;
  logic [DW-1:0]    rd_data, rd_out;
  logic             skid_v, skid_sof, skid_eof;
  logic [DW-1:0]    skid_data;
  logic             out_v, o_sof, o_eof;
  logic [DW-1:0]    o_data;
  logic             ovf_r, err_r;

  logic             pop, last_xfer, out_free, issue;
  logic [1:0]       lvl, lvl_max;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] i);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = i[LOG2N-1-b];
    return r;
  endfunction

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] d);
`ifdef OUT_SCALE_EN
    logic signed [HW-1:0] re, im;
    re = d[DW-1:HW];
    im = d[HW-1:0];
    re = re >>> LOG2N;
    im = im >>> LOG2N;
    return {re, im};
`else
    return d;
`endif
  endfunction

  // Write side
  assign in_rdy     = ~full[wbank];
  assign accept     = bus.in_valid & in_rdy;
  assign resync     = accept & bus.in_sof & (wcnt != '0);
  assign frame_done = accept & ~resync & (wcnt == LAST);
  assign wr_addr    = resync ? '0 : bitrev(wcnt);

  // Read side: the output stage plus skid register form a 2-entry queue; a memory read
  // is only issued when the slot it will land in is guaranteed free.
  assign pop       = out_v & bus.out_ready;
  assign last_xfer = pop & (rcnt == LAST);
  assign out_free  = ~out_v | bus.out_ready;
  assign lvl       = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, rd_v};
  assign lvl_max   = pop ? 2'd2 : 2'd1;
  assign issue     = full[ibank] & (lvl <= lvl_max);
  assign rd_out    = scale(rd_data);

  always_ff @(posedge clk) begin
    if (accept) mem[{wbank, wr_addr}] <= bus.in_data;
    if (issue)  rd_data <= mem[{ibank, iaddr}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      rcnt  <= '0;
      rbank <= 1'b0;
      full  <= 2'b00;
      ovf_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if (bus.in_valid & ~in_rdy) ovf_r <= 1'b1;
      if (accept) begin
        if (resync) begin
          err_r <= 1'b1;
          wcnt  <= LOG2N'(1);
        end else if (wcnt == LAST) begin
          wcnt  <= '0;
          wbank <= ~wbank;
        end else begin
          wcnt  <= wcnt + LOG2N'(1);
        end
      end
      if (pop) begin
        rcnt <= rcnt + LOG2N'(1);
        if (rcnt == LAST) rbank <= ~rbank;
      end
      // Release and fill always target different banks, so both may land together.
      if (last_xfer)  full[rbank] <= 1'b0;
      if (frame_done) full[wbank] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v   <= 1'b0;
      rd_sof <= 1'b0;
      rd_eof <= 1'b0;
      iaddr  <= '0;
      ibank  <= 1'b0;
    end else begin
      rd_v <= issue;
      if (issue) begin
        rd_sof <= (iaddr == '0);
        rd_eof <= (iaddr == LAST);
        iaddr  <= iaddr + LOG2N'(1);
        if (iaddr == LAST) ibank <= ~ibank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v     <= 1'b0;
      o_data    <= '0;
      o_sof     <= 1'b0;
      o_eof     <= 1'b0;
      skid_v    <= 1'b0;
      skid_data <= '0;
      skid_sof  <= 1'b0;
      skid_eof  <= 1'b0;
    end else if (out_free) begin
      if (skid_v) begin
        out_v     <= 1'b1;
        o_data    <= skid_data;
        o_sof     <= skid_sof;
        o_eof     <= skid_eof;
        skid_v    <= rd_v;
        skid_data <= rd_out;
        skid_sof  <= rd_sof;
        skid_eof  <= rd_eof;
      end else begin
        out_v <= rd_v;
        if (rd_v) begin
          o_data <= rd_out;
          o_sof  <= rd_sof;
          o_eof  <= rd_eof;
        end
      end
    end else if (rd_v) begin
      skid_v    <= 1'b1;
      skid_data <= rd_out;
      skid_sof  <= rd_sof;
      skid_eof  <= rd_eof;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_v;
  assign bus.out_data  = o_data;
  assign bus.out_sof   = o_sof;
  assign bus.out_eof   = o_eof;
  assign bus.ovf       = ovf_r;
  assign bus.err       = err_r;
endmodule

// File: tb/tb_sdf_fft_reorder_64.sv
// Randomized bench for sdf_fft_reorder_64 against a frame-level reference model.
module tb_sdf_fft_reorder_64;
  localparam int N     = 64;
  localparam int LOG2N = 6;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int rdy_mode = 0;
  int n_tests = 0;
  int n_fail  = 0;

  sdf_fft_reorder_64_if #(.DW(DW)) bus ();

  sdf_fft_reorder_64 #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model helpers
  function automatic int br(input int k);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if ((k & (1 << b)) != 0) r += N >> (b + 1);
    return r;
  endfunction

`ifdef OUT_SCALE_EN
  function automatic int fdiv(input int v, input int d);
    int q = v / d;
    if ((v % d != 0) && (v < 0)) q--;
    return q;
  endfunction
`endif

  function automatic logic [DW-1:0] ref_out(input logic [DW-1:0] w);
`ifdef OUT_SCALE_EN
    logic signed [15:0] r16, i16;
    int q_re, q_im;
    r16  = w[31:16];
    i16  = w[15:0];
    q_re = fdiv(int'(r16), N);
    q_im = fdiv(int'(i16), N);
    return {q_re[15:0], q_im[15:0]};
`else
    return w;
`endif
  endfunction

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] arr_q[$];
  int            m_pending = 0;
  int            n_out = 0;
  bit            m_ovf = 0, m_err = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_sof, prev_eof;
  bit            m_rdy;

  // Outputs are checked against the model state left by the last edge, then the model
  // is advanced by the handshakes that the coming edge will complete.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      arr_q.delete();
      m_pending  = 0;
      n_out      = 0;
      m_ovf      = 0;
      m_err      = 0;
      prev_stall = 0;
    end else begin
      m_rdy = (m_pending < 2);
      check("in_ready", bus.in_ready, m_rdy);
      check("ovf", bus.ovf, m_ovf);
      check("err", bus.err, m_err);
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, prev_data);
        check("stall_sof", bus.out_sof, prev_sof);
        check("stall_eof", bus.out_eof, prev_eof);
      end
      if (bus.in_valid && !m_rdy) m_ovf = 1;
      if (bus.in_valid && m_rdy) begin
        if (bus.in_sof && arr_q.size() != 0) begin
          m_err = 1;
          arr_q.delete();
        end
        arr_q.push_back(bus.in_data);
        if (arr_q.size() == N) begin
          for (int n = 0; n < N; n++) exp_q.push_back(ref_out(arr_q[br(n)]));
          arr_q.delete();
          m_pending++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", bus.out_data, 'x);
        end else begin
          check("out_data", bus.out_data, exp_q.pop_front());
          check("out_sof", bus.out_sof, n_out == 0);
          check("out_eof", bus.out_eof, n_out == N - 1);
          n_out++;
          if (n_out == N) begin
            n_out = 0;
            m_pending--;
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_sof   = bus.out_sof;
      prev_eof   = bus.out_eof;
    end
  end

  // Downstream ready pattern
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Driver tasks
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input bit sof, input logic [DW-1:0] data, input bit retry);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_data  = data;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.in_ready || !retry) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) break;
    end
    check("drain", exp_q.size() == 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_ramp_frame();
    for (int k = 0; k < N; k++) send(k == 0, {16'(br(k)), 16'h0}, 1);
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_ovf"}, bus.ovf, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned acc_edge;
    bit          seen;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;

    do_reset();
    check_reset_state("reset");

    // Single ramp frame, ready held high: latency and back-to-back burst
    rdy_mode = 0;
    send_ramp_frame();
    acc_edge = cyc;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1;
        break;
      end
    end
    check("first_valid_seen", seen, 1);
    check("first_valid_latency", cyc - acc_edge, 2);
    for (int i = 0; i < N; i++) begin
      check("burst_valid", bus.out_valid, 1);
      @(negedge clk);
    end
    wait_drain();

    // Both banks fill while downstream is blocked; next offer is dropped
    rdy_mode = 3;
    idle(2);
    for (int k = 0; k < 2 * N; k++) send(k % N == 0, $urandom, 1);
    @(negedge clk);
    check("both_full_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    send(1, $urandom, 0);
    @(negedge clk);
    check("drop_ovf", bus.ovf, 1);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    wait_drain();

    // Reset clears sticky flags; ramp frame with a 1,0,0,1 ready pattern
    do_reset();
    check_reset_state("reset2");
    rdy_mode = 1;
    send_ramp_frame();
    wait_drain();

    // Resync: in_sof at arrival 20 of a partial frame
    rdy_mode = 2;
    for (int k = 0; k < 20; k++) send(k == 0, $urandom, 1);
    for (int k = 0; k < N; k++) send(k == 0, $urandom, 1);
    wait_drain();
    @(negedge clk);
    check("resync_err", bus.err, 1);
    @(posedge clk);
    #1;

    // Reset mid-frame discards the partial frame
    for (int k = 0; k < 30; k++) send(k == 0, $urandom, 1);
    do_reset();
    check_reset_state("reset3");

    // Scaling boundary values mixed with random samples
    rdy_mode = 2;
    for (int k = 0; k < N; k++) begin
      case (k % 4)
        0:       send(k == 0, {16'h4000, 16'hFFFF}, 1);
        1:       send(k == 0, {16'h8000, 16'(k)}, 1);
        2:       send(k == 0, {16'h7FFF, 16'h8001}, 1);
        default: send(k == 0, $urandom, 1);
      endcase
    end
    wait_drain();

    // Random traffic: gaps, random ready, optional sof, occasional resync
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 40)); k++) send(k == 0, $urandom, 1);
      end
      for (int k = 0; k < N; k++) begin
        send((k == 0) && ($urandom_range(0, 1) == 1), $urandom, 1);
        if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
